regfile_bypass_sb: RTL and testbench

Parametrised general-purpose register file for the pipelined CPU, with NREAD combinational read ports, one write port, and write-to-read bypass. It also holds an issue scoreboard: one busy bit per register, set when a producer instruction issues and cleared when it writes back. The block sits between decode (read and issue) and writeback (write). It produces the operand values, per-port busy flags and a stall request, so the decode stage needs no separate hazard table.

---
 rtl/rf_pkg.sv | 25 ++
 rtl/rf_scoreboard.sv | 58 +++++
 rtl/regfile_bypass_sb.sv | 91 +++++++++
 tb/tb_regfile_bypass_sb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared widths, reset value and trace formatting for the register file
// Rev     : 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int          RF_DATA_W    = 32;
    localparam int          RF_ADDR_W    = 5;
    localparam logic [31:0] RF_RESET_VAL = 32'h0000_0000;

`ifndef SYNTHESIS
    // Single home for the writeback trace text, e.g. "@00003000: $ 5 <= 12345678"
    function automatic string rf_trace_line(input logic [31:0] pc,
                                            input int unsigned addr,
                                            input logic [31:0] data);
        return $sformatf("@%08h: $%2d <= %08h", pc, addr, data);
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module  : rf_scoreboard
// Brief   : Per-register busy bits with issue/writeback update, read hazards, stall
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    input  logic [NREAD-1:0]        rd_use,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    output logic [NREAD-1:0]        rd_busy,
    output logic                    stall
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Issue is applied after the clear so a same-cycle reissue keeps the bit set
    always_comb begin
        busy_d = '0;
        for (int r = 1; r < DEPTH; r++) begin
            busy_d[r] = (busy_q[r] & ~(wr_en & (wr_addr == ADDR_W'(r))))
                      | (iss_en & (iss_addr == ADDR_W'(r)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd_busy
        logic [ADDR_W-1:0] rd_a;
        assign rd_a       = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_busy[k] = busy_q[rd_a] & ~(wr_en & (wr_addr == rd_a));
    end

    assign stall = |(rd_use & rd_busy);

endmodule

`default_nettype wire

// File: rtl/regfile_bypass_sb.sv
// ============================================================================
// Module  : regfile_bypass_sb
// Brief   : Register file with NREAD bypassed read ports, one write port, scoreboard
// Rev     : 1.0
// ============================================================================
`default_nettype none

module regfile_bypass_sb
    import rf_pkg::*;
#(
    parameter int                DATA_W    = RF_DATA_W,
    parameter int                ADDR_W    = RF_ADDR_W,
    parameter int                NREAD     = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RF_RESET_VAL),
    parameter int                TRACE     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    input  logic [NREAD-1:0]        rd_use,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    output logic                    stall,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [31:0]             wr_pc
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_commit;

    assign wr_commit = wr_en & (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == 0) ? '0 : RESET_VAL;
            end
        end else if (wr_commit) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd_port
        logic [ADDR_W-1:0] rd_a;
        assign rd_a = rd_addr[k*ADDR_W +: ADDR_W];
        always_comb begin
            if (rd_a == '0) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (wr_en && (wr_addr == rd_a)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = mem_q[rd_a];
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREAD  (NREAD)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_use   (rd_use),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_busy  (rd_busy),
        .stall    (stall)
    );

`ifndef SYNTHESIS
    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (!reset && wr_commit) begin
                $display("%s", rf_trace_line(wr_pc, int'(unsigned'(wr_addr)), 32'(wr_data)));
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
// ============================================================================
// Module  : tb_regfile_bypass_sb
// Brief   : Directed vectors against hand-computed values for regfile_bypass_sb
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_bypass_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD-1:0]        rd_use;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_busy;
    logic                    stall;
    logic                    iss_en;
    logic [ADDR_W-1:0]       iss_addr;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [31:0]             wr_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NREAD     (NREAD),
        .RESET_VAL (32'h0),
        .TRACE     (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_use   (rd_use),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .stall    (stall),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_pc    (wr_pc)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_en = 1'b0; iss_addr = '0;
        wr_en  = 1'b0; wr_addr  = '0; wr_data = '0; wr_pc = '0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] use_v);
        rd_addr = {a1, a0};
        rd_use  = use_v;
    endtask

    initial begin
        idle();
        set_rd(5'd0, 5'd0, 2'b00);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Reset state on every address, both ports
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a), 2'b11);
            #1;
            check_vec("rst_rd0",   rd_data[31:0],  32'h0);
            check_vec("rst_rd1",   rd_data[63:32], 32'h0);
            check_vec("rst_busy",  {30'b0, rd_busy}, 32'h0);
            check_vec("rst_stall", {31'b0, stall},   32'h0);
        end

        // Write $5 with same-cycle bypass on both ports, then stored read
        set_rd(5'd5, 5'd5, 2'b11);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678; wr_pc = 32'h3000;
        #1;
        check_vec("byp_rd0", rd_data[31:0],  32'h1234_5678);
        check_vec("byp_rd1", rd_data[63:32], 32'h1234_5678);
        step();
        idle();
        #1;
        check_vec("st_rd0", rd_data[31:0], 32'h1234_5678);

        // Register 0: writes dropped, issues ignored
        set_rd(5'd0, 5'd0, 2'b11);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        check_vec("r0_byp", rd_data[31:0], 32'h0);
        step();
        idle();
        #1;
        check_vec("r0_rd",   rd_data[63:32], 32'h0);
        check_vec("r0_busy", {30'b0, rd_busy}, 32'h0);

        // Issue $8, hazard seen until the writeback cycle
        iss_en = 1'b1; iss_addr = 5'd8;
        step();
        idle();
        set_rd(5'd8, 5'd8, 2'b01);
        #1;
        check_vec("i8_busy",  {30'b0, rd_busy}, 32'h3);
        check_vec("i8_stall", {31'b0, stall},   32'h1);
        set_rd(5'd0, 5'd8, 2'b01);
        #1;
        check_vec("unused_stall", {31'b0, stall}, 32'h0);
        set_rd(5'd8, 5'd8, 2'b01);
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hA;
        #1;
        check_vec("wb8_busy",  {30'b0, rd_busy}, 32'h0);
        check_vec("wb8_stall", {31'b0, stall},   32'h0);
        check_vec("wb8_rd",    rd_data[31:0],    32'hA);
        step();
        idle();
        #1;
        check_vec("post8_busy", {30'b0, rd_busy}, 32'h0);
        check_vec("post8_rd",   rd_data[63:32],   32'hA);

        // Writeback and reissue of $9 in the same cycle: issue wins
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        step();
        idle();
        set_rd(5'd9, 5'd0, 2'b01);
        #1;
        check_vec("reiss9_busy",  {30'b0, rd_busy}, 32'h1);
        check_vec("reiss9_stall", {31'b0, stall},   32'h1);
        check_vec("reiss9_rd",    rd_data[31:0],    32'h99);

        // Outstanding $3/$4 discarded by reset; a write during reset is dropped
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        iss_addr = 5'd4;
        step();
        idle();
        set_rd(5'd3, 5'd4, 2'b11);
        #1;
        check_vec("pre_rst_busy", {30'b0, rd_busy}, 32'h3);
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        iss_en = 1'b1; iss_addr = 5'd6;
        step();
        reset = 1'b0;
        idle();
        #1;
        check_vec("post_rst_busy",  {30'b0, rd_busy}, 32'h0);
        check_vec("post_rst_stall", {31'b0, stall},   32'h0);
        set_rd(5'd5, 5'd6, 2'b11);
        #1;
        check_vec("post_rst_r5", rd_data[31:0],    32'h0);
        check_vec("post_rst_b6", {30'b0, rd_busy}, 32'h0);
        check_vec("post_rst_r9", 32'(dut.u_scoreboard.busy_q[9]), 32'h0);

        // Late writeback to $3 is an ordinary write
        set_rd(5'd3, 5'd0, 2'b01);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; wr_pc = 32'h3010;
        #1;
        check_vec("late3_stall", {31'b0, stall}, 32'h0);
        check_vec("late3_byp",   rd_data[31:0],  32'h55);
        step();
        idle();
        #1;
        check_vec("late3_rd",   rd_data[31:0],    32'h55);
        check_vec("late3_busy", {30'b0, rd_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
